// File: rtl/fp_sum_sequencer_if.sv
// Handshake bundle for fp_sum_sequencer.
//   start/len/busy              : job control
//   in_valid/in_ready/in_data   : element stream (IEEE-754 single)
//   add_a/add_b/add_result/
//   add_overflow/add_underflow  : shared combinational FP adder port
//   out_valid/out_ready/
//   out_sum/out_flags           : result handshake
// slave  = the sequencer, master = the environment driving it.
interface fp_sum_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_result;
  logic             add_overflow;
  logic             add_underflow;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [1:0]       out_flags;

  modport slave (
    input  start, len, in_valid, in_data, add_result, add_overflow,
           add_underflow, out_ready,
    output busy, in_ready, add_a, add_b, out_valid, out_sum, out_flags
  );

  modport master (
    output start, len, in_valid, in_data, add_result, add_overflow,
           add_underflow, out_ready,
    input  busy, in_ready, add_a, add_b, out_valid, out_sum, out_flags
  );
endinterface

// File: rtl/fp_sum_sequencer.sv
// Sequences a vector of IEEE-754 single elements through an external
// combinational FP adder and returns the sum with sticky adder flags.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fp_sum_sequencer_if.slave (control, element stream, adder, result)
module fp_sum_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_sum_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      acc_q;
  logic             acc_empty_q;
  logic [1:0]       flags_q;

  logic accept;
  logic elem_zero;

  assign accept    = (state_q == ACCUM) && bus.in_valid;
  // Zero and denormal elements are counted but never reach the adder result.
  assign elem_zero = (bus.in_data[30:23] == 8'h00);

  // Adder operands are wired straight through; the result is only captured
  // when the element is a nonzero addend to a non-empty accumulator.
  assign bus.add_a     = acc_q;
  assign bus.add_b     = bus.in_data;

  // All outputs decode directly from registered state.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = acc_q;
  assign bus.out_flags = flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= 32'h0000_0000;
      acc_empty_q <= 1'b1;
      flags_q     <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q       <= 32'h0000_0000;
            acc_empty_q <= 1'b1;
            flags_q     <= 2'b00;
            cnt_q       <= bus.len;
            state_q     <= (bus.len == '0) ? DONE : ACCUM;
          end
        end

        ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_q - 1'b1;
            if (!elem_zero) begin
              if (acc_empty_q) begin
                // First real addend seeds the accumulator; adder flags for
                // 0 + x are meaningless and ignored.
                acc_q       <= bus.in_data;
                acc_empty_q <= 1'b0;
              end else begin
                acc_q   <= bus.add_result;
                flags_q <= flags_q | {bus.add_overflow, bus.add_underflow};
              end
            end
            if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_q <= DONE;
          end
        end

        DONE: begin
          // start is deliberately not looked at here, even on the
          // handshake cycle.
          if (bus.out_ready) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sum_sequencer.sv
module tb_fp_sum_sequencer;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sum_sequencer_if #(.CNT_W(CNT_W)) bus ();

  fp_sum_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Injected flag bits for testing stickiness.
  logic ovf_inj, udf_inj;

  // Minimal adder model: positive normal operands, truncating.
  logic [31:0] m_res;
  logic        m_ovf;
  always_comb begin
    logic [7:0]  ea, eb, eh, el;
    logic [23:0] mh, ml;
    logic [24:0] s;
    logic [8:0]  er;
    ea = bus.add_a[30:23];
    eb = bus.add_b[30:23];
    m_res = 32'h0;
    m_ovf = 1'b0;
    if (ea == 8'h00) m_res = bus.add_b;
    else if (eb == 8'h00) m_res = bus.add_a;
    else begin
      if (ea >= eb) begin
        eh = ea; el = eb; mh = {1'b1, bus.add_a[22:0]}; ml = {1'b1, bus.add_b[22:0]};
      end else begin
        eh = eb; el = ea; mh = {1'b1, bus.add_b[22:0]}; ml = {1'b1, bus.add_a[22:0]};
      end
      ml = ml >> (eh - el);
      s  = {1'b0, mh} + {1'b0, ml};
      if (s[24]) begin
        er = {1'b0, eh} + 9'd1;
        m_res = {1'b0, er[7:0], s[23:1]};
      end else begin
        er = {1'b0, eh};
        m_res = {1'b0, er[7:0], s[22:0]};
      end
      m_ovf = (er >= 9'd255);
    end
  end

  assign bus.add_result    = m_res;
  assign bus.add_overflow  = m_ovf | ovf_inj;
  assign bus.add_underflow = udf_inj;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start_job(input logic [CNT_W-1:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    cyc();
    bus.start = 1'b0;
    bus.len   = 8'hAA;   // must not be re-sampled
  endtask

  // One element offered for exactly one cycle.
  task automatic send(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    cyc();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic expect_done(input string tag, input logic [31:0] sum, input logic [1:0] fl);
    chk({tag, "_ov"},  {31'b0, bus.out_valid}, 32'd1);
    chk({tag, "_sum"}, bus.out_sum, sum);
    chk({tag, "_fl"},  {30'b0, bus.out_flags}, {30'b0, fl});
    chk({tag, "_rdy"}, {31'b0, bus.in_ready}, 32'd0);
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_ov"},   {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in_data = 32'h0;
    bus.out_ready = 1'b0;
    ovf_inj = 1'b0; udf_inj = 1'b0;
    repeat (3) cyc();
    // Reset state
    chk("rst_ov",   {31'b0, bus.out_valid}, 32'd0);
    chk("rst_rdy",  {31'b0, bus.in_ready},  32'd0);
    chk("rst_busy", {31'b0, bus.busy},      32'd0);
    chk("rst_sum",  bus.out_sum,            32'h0);
    chk("rst_fl",   {30'b0, bus.out_flags}, 32'd0);
    rst = 1'b0;
    cyc();

    // 1.0 + 2.0 + 3.0 back to back
    start_job(8'd3);
    chk("v1_rdy",  {31'b0, bus.in_ready}, 32'd1);
    chk("v1_busy", {31'b0, bus.busy},     32'd1);
    send(32'h3F80_0000);
    chk("v1_acc1", bus.out_sum, 32'h3F80_0000);
    send(32'h4000_0000);
    chk("v1_acc2", bus.out_sum, 32'h4040_0000);
    chk("v1_ov_early", {31'b0, bus.out_valid}, 32'd0);
    send(32'h4040_0000);
    expect_done("v1", 32'h40C0_0000, 2'b00);
    consume("v1");

    // Zeros counted but skipped; injected flags must be ignored on the seed
    ovf_inj = 1'b1; udf_inj = 1'b1;
    start_job(8'd3);
    send(32'h0000_0000);
    chk("v2_acc0", bus.out_sum, 32'h0);
    send(32'h3F80_0000);
    send(32'h0000_0000);
    expect_done("v2", 32'h3F80_0000, 2'b00);
    ovf_inj = 1'b0; udf_inj = 1'b0;
    consume("v2");

    // len == 0
    start_job(8'd0);
    expect_done("v3", 32'h0, 2'b00);
    consume("v3");

    // Gaps between elements
    start_job(8'd2);
    send(32'h4000_0000);
    repeat (3) begin
      cyc();
      chk("v4_gap_acc", bus.out_sum, 32'h4000_0000);
      chk("v4_gap_ov",  {31'b0, bus.out_valid}, 32'd0);
    end
    send(32'h4000_0000);
    expect_done("v4", 32'h4080_0000, 2'b00);

    // Hold result with out_ready low while start pulses
    for (int i = 0; i < 5; i++) begin
      bus.start = i[0]; bus.len = 8'd5;
      cyc();
      chk("v5_hold_ov",  {31'b0, bus.out_valid}, 32'd1);
      chk("v5_hold_sum", bus.out_sum, 32'h4080_0000);
    end
    // start coincident with handshake is ignored
    bus.start = 1'b1; bus.out_ready = 1'b1;
    cyc();
    bus.start = 1'b0; bus.out_ready = 1'b0;
    chk("v5_idle_ov",   {31'b0, bus.out_valid}, 32'd0);
    chk("v5_idle_busy", {31'b0, bus.busy}, 32'd0);
    cyc();
    chk("v5_no_start",  {31'b0, bus.busy}, 32'd0);

    // Sticky flags from the adder
    start_job(8'd3);
    send(32'h3F80_0000);
    ovf_inj = 1'b1;
    send(32'h3F80_0000);
    ovf_inj = 1'b0; udf_inj = 1'b1;
    send(32'h0000_0000);    // zero: flags must not pick up underflow
    udf_inj = 1'b0;
    expect_done("v6", 32'h4000_0000, 2'b10);
    consume("v6");

    // Reset mid-accumulation
    start_job(8'd4);
    send(32'h3F80_0000);
    send(32'h3F80_0000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("v7_rdy",  {31'b0, bus.in_ready}, 32'd0);
    chk("v7_busy", {31'b0, bus.busy}, 32'd0);
    chk("v7_sum",  bus.out_sum, 32'h0);
    chk("v7_ov",   {31'b0, bus.out_valid}, 32'd0);
    cyc();
    chk("v7_stay", {31'b0, bus.busy}, 32'd0);
    start_job(8'd1);
    send(32'h3F80_0000);
    expect_done("v8", 32'h3F80_0000, 2'b00);
    consume("v8");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp_sum_sequencer.md
FP_SUM_SEQUENCER -- requirements
Module: fp_sum_sequencer

Interface
REQ-001 Parameter: CNT_W, default 8, width of the vector-length field and element counter.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  pulse requesting a new accumulation; sampled only in IDLE.
REQ-005 Port: len  input  CNT_W  number of IEEE-754 single elements to sum; sampled with start.
REQ-006 Port: busy  output  1  high in ACCUM and DONE.
REQ-007 Port: in_valid  input  1  element stream valid.
REQ-008 Port: in_ready  output  1  element stream ready.
REQ-009 Port: in_data  input  32  element value, IEEE-754 single.
REQ-010 Port: add_a  output  32  operand A to the shared combinational FP adder.
REQ-011 Port: add_b  output  32  operand B to the shared combinational FP adder.
REQ-012 Port: add_result  input  32  adder sum, valid in the same cycle as add_a/add_b.
REQ-013 Port: add_overflow  input  1  adder overflow flag, same-cycle.
REQ-014 Port: add_underflow  input  1  adder underflow flag, same-cycle.
REQ-015 Port: out_valid  output  1  result valid.
REQ-016 Port: out_ready  input  1  result accepted by consumer.
REQ-017 Port: out_sum  output  32  accumulated sum.
REQ-018 Port: out_flags  output  2  {sticky overflow, sticky underflow} for the vector.

Function
REQ-019 FSM states: IDLE, ACCUM, DONE; encoding free.
REQ-020 IDLE: start=1 and len!=0 -> ACCUM; cnt<=len; acc<=0x00000000; acc_empty<=1; flags<=0.
REQ-021 IDLE: start=1 and len==0 -> DONE with acc=0x00000000, flags=0.
REQ-022 start outside IDLE is ignored; len is not re-sampled.
REQ-023 in_ready=1 exactly when state==ACCUM; in_ready=0 in IDLE and DONE.
REQ-024 Element accepted on a cycle with in_valid && in_ready; at most one element per cycle.
REQ-025 add_a = acc and add_b = in_data combinationally at all times.
REQ-026 Accepted element with exponent field in_data[30:23]==0 (zero/denormal): acc, acc_empty and flags unchanged; element still counted.
REQ-027 Accepted nonzero element with acc_empty=1: acc<=in_data; acc_empty<=0; adder flags ignored.
REQ-028 Accepted nonzero element with acc_empty=0: acc<=add_result; flags<=flags | {add_overflow, add_underflow}.
REQ-029 Every accepted element decrements cnt by 1; accept with cnt==1 -> DONE next cycle.
REQ-030 Cycles in ACCUM without in_valid hold all state; no timeout.
REQ-031 DONE: out_valid=1; out_sum=acc; out_flags=flags; all three stable until the handshake completes.
REQ-032 DONE with out_ready=1 -> IDLE next cycle; out_valid=0 from that cycle.
REQ-033 out_valid=0 in IDLE and ACCUM; out_sum reflects acc in all states.
REQ-034 Latency: out_valid rises the cycle after the last element is accepted; throughput 1 element/cycle.
REQ-035 A start asserted in the same cycle as the DONE->IDLE handshake is ignored; start must be presented in IDLE.

Reset
REQ-036 rst=1 at a clock edge, in any state including mid-ACCUM: state<=IDLE; acc<=0; cnt<=0; acc_empty<=1; flags<=0.
REQ-037 During and after reset until next start: out_valid=0, in_ready=0, busy=0, out_sum=0x00000000, out_flags=2'b00.
REQ-038 A partially accumulated vector is discarded on reset; no output is produced for it.

Verification
REQ-039 len=3; in 0x3F800000, 0x40000000, 0x40400000 back-to-back -> out_valid 1 cycle after third accept; out_sum=0x40C00000 (6.0); out_flags=00.
REQ-040 len=3; in 0x00000000, 0x3F800000, 0x00000000 -> out_sum=0x3F800000; adder result never captured.
REQ-041 len=0 start -> DONE next cycle; out_sum=0x00000000; in_ready never asserted.
REQ-042 len=2; in_valid gaps of 3 idle cycles between 0x40000000 and 0x40000000 -> out_sum=0x40800000 (4.0); acc held during gaps.
REQ-043 Result ready; out_ready held low 5 cycles with start pulsing -> out_sum/out_flags stable; start ignored; IDLE 1 cycle after out_ready=1.
REQ-044 len=4; rst pulsed after 2 accepts -> next cycle in_ready=0, busy=0, out_sum=0; fresh len=1 with 0x3F800000 -> out_sum=0x3F800000.
